modulo_arbitro_mux8: RTL and testbench
======================================

Name: modulo_arbitro_mux8

Overview:
- Round-robin arbiter that shares one 8:1 select mux between 8 requesters.
- Sequences the mux select lines: grants one channel at a time, holds it for a bounded number of cycles, then rotates to the next pending requester.
- Sits directly in front of the 8:1 mux and drives its 3-bit select.
- Requester i is routed through mux data input i.

Parameters:
HOLD_CYCLES, 4, maximum consecutive cycles one grant is held; legal range 1..255.

Ports:
input_clk      input   1  system clock, rising edge
input_reset_n  input   1  asynchronous, active-low reset
input_enable   input   1  arbitration enable; low forces release and blocks new grants
input_req      input   8  request vector, bit i = requester i
out_sel        output  3  select to the 8:1 mux (see mapping below)
out_grant      output  8  one-hot grant, all zero when idle
out_idx        output  3  binary index of the granted requester
out_valid      output  1  high while a grant is active

Behaviour:
- Mux mapping: the mux routes data input 7 when select = 0 and data input 0 when select = 7. Therefore out_sel = bitwise NOT of out_idx (idx 4 -> sel 3'b011). This holds at all times, including reset.
- All outputs are registered.
- Internal state:
  - FSM with states IDLE and SERVE.
  - Round-robin pointer ptr, 3 bits.
  - Hold counter cnt, 8 bits.
- Reset (asynchronous, immediate):
  - state = IDLE, ptr = 0, cnt = 0, out_idx = 0.
  - out_sel = 3'b111, out_grant = 0, out_valid = 0.
- Pick function: the first requester with req = 1, searching circularly from ptr (ptr, ptr+1, ..., 7, 0, ...). Simultaneous requests resolve by smallest circular distance from ptr.
- IDLE:
  - If input_enable = 1 and at least one req bit is high: at the next edge load the picked index into out_idx and out_grant, set out_valid = 1, cnt = 1, go to SERVE.
  - Otherwise remain in IDLE; outputs unchanged.
  - Latency: a request sampled at edge N is granted and visible after edge N.
- SERVE, release condition: req[out_idx] = 0, OR cnt == HOLD_CYCLES, OR input_enable = 0.
- SERVE, no release: cnt increments; grant unchanged.
- SERVE, release, common steps:
  - ptr = out_idx + 1 mod 8 (7 wraps to 0).
  - The pick is evaluated using this new ptr against the current req.
- SERVE, release with enable = 1 and a pick found: back-to-back grant at the same edge, with no idle cycle.
  - New idx, new grant, cnt = 1, stay in SERVE, out_valid stays 1.
  - This also applies when the only pending requester is the one just released: it is regranted.
- SERVE, release with enable = 0 or no requests:
  - Go to IDLE; out_valid = 0, out_grant = 0.
  - out_idx and out_sel keep their last values.
- Request behaviour within a grant:
  - A requester dropping req releases at the next edge, even when cnt = 1.
  - New requests arriving during a grant are not considered until release.
- Reset asserted mid-SERVE: grant removed asynchronously, with no completion of the hold.
- out_grant is always one-hot or zero; never more than one bit set.

Decomposition:
- Shared package:
  - NUM_CH = 8, SEL_W = 3.
  - State encoding IDLE = 1'b0, SERVE = 1'b1.
  - CNT_W = 8.
- One combinational sub-module, modulo_rr_pick8:
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, idx[2:0].
  - Implements the circular priority search.
- The top level holds the FSM, counter, pointer and output registers.

Test Plan:
1. Reset: pulse input_reset_n low mid-SERVE between clock edges -> out_valid = 0, out_grant = 0, out_sel = 3'b111 immediately, before the next edge.
2. Single requester: HOLD_CYCLES = 4, enable = 1, req = 8'b00010000 held -> one edge later grant = 8'b00010000, idx = 4, sel = 3'b011. After the 4th cycle it is regranted back-to-back; out_valid stays 1 continuously.
3. Fairness: ptr = 0, req = 8'b10000001 held -> ch0 (sel = 3'b111) for 4 cycles, then ch7 (sel = 3'b000) for 4 cycles, then ch0 again; no gap cycles.
4. Early drop: ch2 granted, req[2] falls after 2 cycles with req[5] = 1 -> next edge grant = 8'b00100000, idx = 5, sel = 3'b010, cnt restarts.
5. Enable gating: drop enable during SERVE -> next edge out_valid = 0, grant = 0, out_sel holds. Re-enable with the same req -> grant resumes from ptr = old idx + 1.
6. Wrap and idle: ch7 released with req = 8'b00000010 -> ch1 granted. Then req = 0 -> IDLE, out_valid = 0; a new req[6] is granted one edge after it is sampled.

Source files
------------

// File: rtl/modulo_arbitro_mux8_pkg.sv
// rtl/modulo_arbitro_mux8_pkg.sv - shared constants, state encoding and helpers for the mux8 arbiter
package modulo_arbitro_mux8_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] v_onehot;
        v_onehot      = '0;
        v_onehot[idx] = 1'b1;
        return v_onehot;
    endfunction

    // The shared mux routes data input 7 on select 0, so select is the inverted index.
    function automatic logic [SEL_W-1:0] idx_to_sel(input logic [SEL_W-1:0] idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/modulo_rr_pick8.sv
// rtl/modulo_rr_pick8.sv - circular priority search over 8 requests starting at ptr
module modulo_rr_pick8
    import modulo_arbitro_mux8_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic              o_found,
    output logic [SEL_W-1:0]  o_idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk from the farthest candidate back to ptr so the nearest hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_ptr;
        w_cand  = i_ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_cand = i_ptr + SEL_W'(k);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/modulo_arbitro_mux8.sv
// rtl/modulo_arbitro_mux8.sv - round-robin arbiter driving the select of a shared 8:1 mux
module modulo_arbitro_mux8
    import modulo_arbitro_mux8_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
)
(
    input  logic              input_clk,
    input  logic              input_reset_n,
    input  logic              input_enable,
    input  logic [NUM_CH-1:0] input_req,
    output logic [SEL_W-1:0]  out_sel,
    output logic [NUM_CH-1:0] out_grant,
    output logic [SEL_W-1:0]  out_idx,
    output logic              out_valid
);

    state_t             r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_CH-1:0]  r_grant;
    logic               r_valid;

    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [NUM_CH-1:0]  w_grant_nxt;
    logic               w_valid_nxt;

    logic [SEL_W-1:0]   w_pick_ptr;
    logic               w_found;
    logic [SEL_W-1:0]   w_pick_idx;
    logic               w_hold_done;
    logic               w_release;
    logic               w_grant_ok;

    // On release the search restarts just past the channel being let go.
    assign w_pick_ptr  = (r_state == ST_SERVE) ? r_idx + SEL_W'(1) : r_ptr;
    assign w_hold_done = (r_cnt == CNT_W'(HOLD_CYCLES));
    assign w_release   = (r_state == ST_SERVE) &&
                         (!input_req[r_idx] || w_hold_done || !input_enable);
    assign w_grant_ok  = input_enable && w_found;

    modulo_rr_pick8 u_pick (
        .i_req   (input_req),
        .i_ptr   (w_pick_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge input_clk or negedge input_reset_n) begin
        if (!input_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_ok) begin
                    w_state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (w_release && !w_grant_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_sel_nxt   = r_sel;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_ok) begin
                    w_idx_nxt   = w_pick_idx;
                    w_sel_nxt   = idx_to_sel(w_pick_idx);
                    w_grant_nxt = idx_to_onehot(w_pick_idx);
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_SERVE: begin
                if (!w_release) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_ptr_nxt = w_pick_ptr;
                    if (w_grant_ok) begin
                        w_idx_nxt   = w_pick_idx;
                        w_sel_nxt   = idx_to_sel(w_pick_idx);
                        w_grant_nxt = idx_to_onehot(w_pick_idx);
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        // Index and select are left on the last channel while idle.
                        w_grant_nxt = '0;
                        w_valid_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge input_clk or negedge input_reset_n) begin
        if (!input_reset_n) begin
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sel   <= idx_to_sel('0);
            r_grant <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sel   <= w_sel_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign out_sel   = r_sel;
    assign out_grant = r_grant;
    assign out_idx   = r_idx;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_modulo_arbitro_mux8.sv
// tb/tb_modulo_arbitro_mux8.sv - directed table-driven bench for modulo_arbitro_mux8
module tb_modulo_arbitro_mux8;

    typedef struct {
        bit         rst;
        logic       en;
        logic [7:0] req;
        logic       valid;
        logic [7:0] grant;
        logic [2:0] idx;
        logic [2:0] sel;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [2:0] out_sel;
    logic [7:0] out_grant;
    logic [2:0] out_idx;
    logic       out_valid;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    modulo_arbitro_mux8 #(.HOLD_CYCLES(4)) dut (
        .input_clk     (clk),
        .input_reset_n (rst_n),
        .input_enable  (en),
        .input_req     (req),
        .out_sel       (out_sel),
        .out_grant     (out_grant),
        .out_idx       (out_idx),
        .out_valid     (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, logic e, logic [7:0] q, logic v,
                                logic [7:0] g, logic [2:0] i, logic [2:0] s);
        vec_t t;
        t.rst = r; t.en = e; t.req = q; t.valid = v; t.grant = g; t.idx = i; t.sel = s;
        return t;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [7:0] g,
                            input logic [2:0] i, input logic [2:0] s);
        chk({tag, " valid"}, {7'd0, out_valid}, {7'd0, v});
        chk({tag, " grant"}, out_grant, g);
        chk({tag, " idx"},   {5'd0, out_idx}, {5'd0, i});
        chk({tag, " sel"},   {5'd0, out_sel}, {5'd0, s});
        chk({tag, " onehot"}, {7'd0, ($countones(out_grant) <= 1)}, 8'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;

        // single requester held across the hold boundary, then drop to idle
        vecs.push_back(mk(0, 1, 8'h10, 1, 8'h10, 3'd4, 3'b011));
        vecs.push_back(mk(0, 1, 8'h10, 1, 8'h10, 3'd4, 3'b011));
        vecs.push_back(mk(0, 1, 8'h10, 1, 8'h10, 3'd4, 3'b011));
        vecs.push_back(mk(0, 1, 8'h10, 1, 8'h10, 3'd4, 3'b011));
        vecs.push_back(mk(0, 1, 8'h10, 1, 8'h10, 3'd4, 3'b011));
        vecs.push_back(mk(0, 1, 8'h00, 0, 8'h00, 3'd4, 3'b011));
        // fairness between ch0 and ch7 from ptr 0
        vecs.push_back(mk(1, 1, 8'h81, 1, 8'h01, 3'd0, 3'b111));
        vecs.push_back(mk(0, 1, 8'h81, 1, 8'h01, 3'd0, 3'b111));
        vecs.push_back(mk(0, 1, 8'h81, 1, 8'h01, 3'd0, 3'b111));
        vecs.push_back(mk(0, 1, 8'h81, 1, 8'h01, 3'd0, 3'b111));
        vecs.push_back(mk(0, 1, 8'h81, 1, 8'h80, 3'd7, 3'b000));
        vecs.push_back(mk(0, 1, 8'h81, 1, 8'h80, 3'd7, 3'b000));
        vecs.push_back(mk(0, 1, 8'h81, 1, 8'h80, 3'd7, 3'b000));
        vecs.push_back(mk(0, 1, 8'h81, 1, 8'h80, 3'd7, 3'b000));
        vecs.push_back(mk(0, 1, 8'h81, 1, 8'h01, 3'd0, 3'b111));
        // early drop of ch2 hands over to ch5
        vecs.push_back(mk(0, 1, 8'h04, 1, 8'h04, 3'd2, 3'b101));
        vecs.push_back(mk(0, 1, 8'h24, 1, 8'h04, 3'd2, 3'b101));
        vecs.push_back(mk(0, 1, 8'h20, 1, 8'h20, 3'd5, 3'b010));
        vecs.push_back(mk(0, 1, 8'h20, 1, 8'h20, 3'd5, 3'b010));
        // enable gating, resume from ptr 6
        vecs.push_back(mk(0, 0, 8'h20, 0, 8'h00, 3'd5, 3'b010));
        vecs.push_back(mk(0, 0, 8'h21, 0, 8'h00, 3'd5, 3'b010));
        vecs.push_back(mk(0, 1, 8'h21, 1, 8'h01, 3'd0, 3'b111));
        // wrap from ch7 to ch1, idle, then fresh request
        vecs.push_back(mk(0, 1, 8'h80, 1, 8'h80, 3'd7, 3'b000));
        vecs.push_back(mk(0, 1, 8'h02, 1, 8'h02, 3'd1, 3'b110));
        vecs.push_back(mk(0, 1, 8'h00, 0, 8'h00, 3'd1, 3'b110));
        vecs.push_back(mk(0, 1, 8'h40, 1, 8'h40, 3'd6, 3'b001));

        #12;
        chk_outs("reset", 1'b0, 8'h00, 3'd0, 3'b111);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            if (vecs[n].rst) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                #1;
            end
            en  = vecs[n].en;
            req = vecs[n].req;
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", n), vecs[n].valid, vecs[n].grant,
                     vecs[n].idx, vecs[n].sel);
        end

        // asynchronous reset while ch6 is being served
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 1'b0, 8'h00, 3'd0, 3'b111);
        @(posedge clk);
        #1;
        chk_outs("rst_held", 1'b0, 8'h00, 3'd0, 3'b111);
        rst_n = 1'b1;

        // grant visible exactly one edge after the request is sampled
        req = 8'h08;
        en  = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("latency", 1'b1, 8'h08, 3'd3, 3'b100);

        // ch0 joins during ch3's grant; ch3 keeps it until the hold expires
        req = 8'h09;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("hold_keep grant", out_grant, 8'h08);
        end
        @(posedge clk);
        #1;
        chk_outs("hold_rotate", 1'b1, 8'h01, 3'd0, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
